// File: rtl/regfile_dump.sv
// Debug read-out engine: walks every register-file entry, streams each value
// with its index over valid/ready, and accumulates a wrapping checksum.
module regfile_dump #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic                     abort_i,
    output logic [ADDRESS_WIDTH-1:0] rf_addr_o,
    input  logic [DATA_WIDTH-1:0]    rf_data_i,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic [DATA_WIDTH-1:0]    data_o,
    output logic [ADDRESS_WIDTH-1:0] idx_o,
    output logic                     last_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic [DATA_WIDTH-1:0]    sum_o
);

    localparam logic [ADDRESS_WIDTH-1:0] LAST_IDX = {ADDRESS_WIDTH{1'b1}};
    localparam logic [ADDRESS_WIDTH-1:0] ZERO_IDX = {ADDRESS_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0]    ZERO_DAT = {DATA_WIDTH{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SEND  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [ADDRESS_WIDTH-1:0] r_idx;
    logic [ADDRESS_WIDTH-1:0] w_idx_nxt;
    logic [ADDRESS_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0]    r_data;
    logic [DATA_WIDTH-1:0]    w_data_nxt;
    logic [DATA_WIDTH-1:0]    r_sum;
    logic [DATA_WIDTH-1:0]    w_sum_nxt;
    logic                     r_valid;
    logic                     r_busy;
    logic                     r_done;
    logic                     r_last;
    logic                     w_active_nxt;

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and datapath updates; abort wins over a same-cycle handshake
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_data_nxt  = r_data;
        w_sum_nxt   = r_sum;
        case (r_state)
            ST_IDLE: begin
                if (start_i) begin
                    w_idx_nxt   = ZERO_IDX;
                    w_sum_nxt   = ZERO_DAT;
                    w_state_nxt = ST_FETCH;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (abort_i) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_data_nxt  = rf_data_i;
                    w_state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                if (abort_i) begin
                    w_state_nxt = ST_IDLE;
                end else if (ready_i) begin
                    w_sum_nxt = r_sum + r_data;
                    if (r_idx == LAST_IDX) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_idx_nxt   = r_idx + {{(ADDRESS_WIDTH-1){1'b0}}, 1'b1};
                        w_state_nxt = ST_FETCH;
                    end
                end else begin
                    w_state_nxt = ST_SEND;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_active_nxt = (w_state_nxt == ST_FETCH) || (w_state_nxt == ST_SEND);

    // Datapath and registered outputs, decoded from the upcoming state
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_idx   <= ZERO_IDX;
            r_addr  <= ZERO_IDX;
            r_data  <= ZERO_DAT;
            r_sum   <= ZERO_DAT;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            r_idx   <= w_idx_nxt;
            r_addr  <= w_active_nxt ? w_idx_nxt : ZERO_IDX;
            r_data  <= w_data_nxt;
            r_sum   <= w_sum_nxt;
            r_valid <= (w_state_nxt == ST_SEND);
            r_busy  <= w_active_nxt;
            r_done  <= (w_state_nxt == ST_DONE);
            r_last  <= (w_state_nxt == ST_SEND) && (w_idx_nxt == LAST_IDX);
        end
    end

    assign rf_addr_o = r_addr;
    assign valid_o   = r_valid;
    assign data_o    = r_data;
    assign idx_o     = r_idx;
    assign last_o    = r_last;
    assign busy_o    = r_busy;
    assign done_o    = r_done;
    assign sum_o     = r_sum;

endmodule

// File: doc/regfile_dump.md
Name: regfile_dump

Overview:
Debug read-out engine for the integer register file. It acts as the reader side of the register-file read port: on a start pulse it walks every architectural register in order, drives the read address, and captures the combinational read data. It streams each value out over a valid/ready handshake with its index, and reports a modulo-2^DATA_WIDTH checksum at the end. It sits beside the core on a spare read port and is used by the testbench and debug logic for post-program state checks.

Parameters:
ADDRESS_WIDTH, 5, register index width; number of registers dumped = 2**ADDRESS_WIDTH
DATA_WIDTH, 32, register data width

Ports:
clk_i  input  1  clock; all state updates on rising edge
rst_i  input  1  asynchronous active-high reset
start_i  input  1  begin dump; sampled only in IDLE
abort_i  input  1  cancel dump in progress
rf_addr_o  output  ADDRESS_WIDTH  read address to register file read port
rf_data_i  input  DATA_WIDTH  combinational read data from register file
valid_o  output  1  dump beat available
ready_i  input  1  consumer accepts beat
data_o  output  DATA_WIDTH  captured register value
idx_o  output  ADDRESS_WIDTH  index of register in data_o
last_o  output  1  current beat is index 2**ADDRESS_WIDTH-1
busy_o  output  1  dump in progress (FETCH or SEND)
done_o  output  1  one-cycle pulse, dump completed
sum_o  output  DATA_WIDTH  running checksum; final value valid when done_o=1

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is asynchronous and active-high.
- Reset: state IDLE. idx, data_q and sum cleared to 0. All outputs 0, effective immediately on rst_i assertion, regardless of state.
- States:
  - IDLE:
    - rf_addr_o=0, busy_o=0.
    - start_i=1 -> idx<=0, sum<=0, go to FETCH.
  - FETCH:
    - rf_addr_o=idx.
    - At edge: data_q<=rf_data_i, go to SEND.
    - valid_o=0.
  - SEND:
    - valid_o=1, data_o=data_q, idx_o=idx, last_o=(idx==2**ADDRESS_WIDTH-1). rf_addr_o holds idx.
    - On edge with ready_i=1: sum<=sum+data_q, truncated to DATA_WIDTH. If last_o, go to DONE; else idx<=idx+1 and go to FETCH.
    - ready_i=0: hold state. data_o, idx_o and last_o stay stable.
  - DONE:
    - done_o=1 for exactly one cycle. sum_o holds final sum.
    - Unconditionally go to IDLE.
- busy_o=1 in FETCH and SEND only.
- Latency:
  - start sampled at edge N -> FETCH in cycle N+1 -> first valid_o in cycle N+2.
  - With ready_i held high, one beat every 2 cycles.
  - done_o 1 cycle after the last beat is accepted.
- start_i outside IDLE is ignored. It is not queued.
- abort_i:
  - In FETCH or SEND, abort_i=1 -> IDLE at next edge. No done_o pulse.
  - sum_o keeps the partial value until the next start.
  - abort_i has priority over a simultaneous ready_i handshake: the beat is not counted.
  - In IDLE and DONE, abort_i is ignored.
- idx does not wrap within a dump. The last index terminates via last_o.
- No special case for x0. The block reports whatever rf_data_i returns (0 for x0).
- sum_o stays readable in IDLE after completion until the next start clears it.

Test Plan:
- Full dump: preload x_i = i*0x10, ready_i=1, pulse start_i -> first valid 2 cycles after start. 32 beats at idx 0..31 with data i*0x10. last_o only on idx 31. done_o one cycle. sum_o=0x1F00.
- Backpressure: drop ready_i for 5 cycles while idx_o=3 -> valid_o stays 1. data_o=0x30 and idx_o=3 are stable. Beat is accepted once ready_i returns. Final sum still 0x1F00.
- Start while busy: pulse start_i at idx 7 -> dump continues uninterrupted. Exactly 32 beats and one done_o.
- Abort: assert abort_i in SEND at idx 10 -> busy_o=0 and valid_o=0 next cycle. No done_o. sum_o=0x2D0 (sum of 0..9 ×0x10). A fresh start restarts at idx 0.
- Checksum wrap: x5=x6=0xFFFFFFFF, all others 0 -> sum_o=0xFFFFFFFE at done_o.
- Async reset: assert rst_i between edges during SEND -> valid_o, busy_o, data_o and sum_o go to 0 immediately. After release, the block is IDLE and accepts start_i.
